// File: rtl/chol_inv_sequencer_pkg.sv
// Shared types and helpers for the Cholesky factor-and-invert sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package chol_inv_pkg;

   // Sequencer phases, one per pipeline activity window
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SQRT      = 3'd1,
      CDIV      = 3'd2,
      CMAC_IDIV = 3'd3,
      IDIV      = 3'd4,
      IMAC      = 3'd5,
      DONE      = 3'd6
   } phase_t;

   // Owner of a shared arithmetic unit
   typedef enum logic [1:0] {
      NONE = 2'd0,
      CHOL = 2'd1,
      INV  = 2'd2
   } owner_t;

   // Largest of three latencies, used to size the phase counter
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/chol_inv_sequencer_if.sv
// Control/status bundle between a run requester and the sequencer.
// Latency: n/a (wires only).
// Backpressure: none; start is dropped by the sequencer while a run is active.
interface chol_inv_sequencer_if
   import chol_inv_pkg::*;
#(
   parameter int N      = 6,
   parameter int STEP_W = 6
);
   logic                 start;
   logic                 abort;
   logic                 busy;
   logic                 done;
   logic [$clog2(N)-1:0] col;
   logic [STEP_W-1:0]    chol_step;
   logic [STEP_W-1:0]    inv_step;
   logic                 div_en;
   owner_t               div_sel;
   logic                 mult_en;
   owner_t               mult_sel;
   logic                 sqrt_en;

   modport master (
      output start, abort,
      input  busy, done, col, chol_step, inv_step,
      input  div_en, div_sel, mult_en, mult_sel, sqrt_en
   );

   modport slave (
      input  start, abort,
      output busy, done, col, chol_step, inv_step,
      output div_en, div_sel, mult_en, mult_sel, sqrt_en
   );
endinterface

// File: rtl/chol_inv_sequencer_phase_timer.sv
// Loadable down-counter timing one sequencer phase; zero marks the last cycle.
// Latency: load takes effect on the next edge; counter saturates at 0.
// Backpressure: none.
module phase_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero,
   output logic [W-1:0] nxt
);
   logic [W-1:0] cnt;

   // Next count: load wins, otherwise count down and hold at zero
   always_comb begin
      nxt = cnt;
      if (load) begin
         nxt = load_val;
      end else if (cnt != '0) begin
         nxt = cnt - W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         cnt <= nxt;
      end
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/chol_inv_sequencer.sv
// Sequences sqrt/divide/multiply-accumulate phases for an N-column Cholesky factor-and-invert.
// Latency: outputs registered, first phase cycle one edge after start; done one cycle after last phase.
// Backpressure: start ignored while busy or in DONE; abort cancels a run on the next edge.
module chol_inv_sequencer
   import chol_inv_pkg::*;
#(
   parameter int N        = 6,
   parameter int SQRT_LAT = 5,
   parameter int DIV_LAT  = 5,
   parameter int MAC_LAT  = 6,
   parameter int STEP_W   = 6
) (
   input  logic               clk,
   input  logic               rst,
   chol_inv_sequencer_if.slave bus
);
   // Overlapped phase covers both the Cholesky MAC and the inverse divide
   localparam int CM_LAT = (MAC_LAT > DIV_LAT) ? MAC_LAT : DIV_LAT;
   localparam int PH_W   = $clog2(max3(SQRT_LAT, DIV_LAT, MAC_LAT) + 1);
   localparam int COL_W  = $clog2(N);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(N - 1);
   // Counter values at or above this keep the divider busy inside CMAC_IDIV
   localparam int DIV_WIN = CM_LAT - DIV_LAT;

   phase_t            state_q, state_d;
   logic              ph_load;
   logic [PH_W-1:0]   ph_val;
   logic [PH_W-1:0]   ph_nxt;
   logic              ph_zero;
   logic [COL_W-1:0]  col_q, col_d;
   logic [STEP_W-1:0] chol_q, chol_d;
   logic [STEP_W-1:0] inv_q, inv_d;
   logic              running;

   logic   busy_q, busy_d;
   logic   done_q, done_d;
   logic   sqrt_q, sqrt_d;
   logic   div_en_q, div_en_d;
   owner_t div_sel_q, div_sel_d;
   logic   mult_en_q, mult_en_d;
   owner_t mult_sel_q, mult_sel_d;

   phase_timer #(.W(PH_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (ph_load),
      .load_val (ph_val),
      .zero     (ph_zero),
      .nxt      (ph_nxt)
   );

   assign running = state_q inside {SQRT, CDIV, CMAC_IDIV, IDIV, IMAC};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, phase counter load and column/step bookkeeping
   always_comb begin
      state_d = state_q;
      ph_load = 1'b0;
      ph_val  = '0;
      col_d   = col_q;
      chol_d  = chol_q;
      inv_d   = inv_q;

      if (bus.abort && running) begin
         state_d = IDLE;
         ph_load = 1'b1;
         col_d   = '0;
         chol_d  = '0;
         inv_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  state_d = SQRT;
                  ph_load = 1'b1;
                  ph_val  = PH_W'(SQRT_LAT - 1);
                  col_d   = '0;
                  chol_d  = STEP_W'(1);
                  inv_d   = '0;
               end
            end
            SQRT: begin
               if (ph_zero) begin
                  ph_load = 1'b1;
                  ph_val  = PH_W'(DIV_LAT - 1);
                  if (col_q != COL_LAST) begin
                     state_d = CDIV;
                     chol_d  = chol_q + STEP_W'(1);
                  end else begin
                     state_d = IDIV;
                     inv_d   = inv_q + STEP_W'(1);
                  end
               end
            end
            CDIV: begin
               if (ph_zero) begin
                  state_d = CMAC_IDIV;
                  ph_load = 1'b1;
                  ph_val  = PH_W'(CM_LAT - 1);
                  chol_d  = chol_q + STEP_W'(1);
                  inv_d   = inv_q + STEP_W'(1);
               end
            end
            CMAC_IDIV, IDIV: begin
               if (ph_zero) begin
                  state_d = IMAC;
                  ph_load = 1'b1;
                  ph_val  = PH_W'(MAC_LAT - 1);
                  inv_d   = inv_q + STEP_W'(1);
               end
            end
            IMAC: begin
               if (ph_zero) begin
                  if (col_q != COL_LAST) begin
                     state_d = SQRT;
                     ph_load = 1'b1;
                     ph_val  = PH_W'(SQRT_LAT - 1);
                     col_d   = col_q + COL_W'(1);
                     chol_d  = chol_q + STEP_W'(1);
                  end else begin
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Output decode from the upcoming state so every output comes straight from a flop
   always_comb begin
      busy_d     = 1'b0;
      done_d     = 1'b0;
      sqrt_d     = 1'b0;
      div_en_d   = 1'b0;
      div_sel_d  = NONE;
      mult_en_d  = 1'b0;
      mult_sel_d = NONE;
      case (state_d)
         SQRT: begin
            busy_d = 1'b1;
            sqrt_d = 1'b1;
         end
         CDIV: begin
            busy_d    = 1'b1;
            div_en_d  = 1'b1;
            div_sel_d = CHOL;
         end
         CMAC_IDIV: begin
            busy_d     = 1'b1;
            mult_en_d  = 1'b1;
            mult_sel_d = CHOL;
            if (int'(ph_nxt) >= DIV_WIN) begin
               div_en_d  = 1'b1;
               div_sel_d = INV;
            end
         end
         IDIV: begin
            busy_d    = 1'b1;
            div_en_d  = 1'b1;
            div_sel_d = INV;
         end
         IMAC: begin
            busy_d     = 1'b1;
            mult_en_d  = 1'b1;
            mult_sel_d = INV;
         end
         DONE: begin
            done_d = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // Column, step and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q      <= '0;
         chol_q     <= '0;
         inv_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sqrt_q     <= 1'b0;
         div_en_q   <= 1'b0;
         div_sel_q  <= NONE;
         mult_en_q  <= 1'b0;
         mult_sel_q <= NONE;
      end else begin
         col_q      <= col_d;
         chol_q     <= chol_d;
         inv_q      <= inv_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         sqrt_q     <= sqrt_d;
         div_en_q   <= div_en_d;
         div_sel_q  <= div_sel_d;
         mult_en_q  <= mult_en_d;
         mult_sel_q <= mult_sel_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.col       = col_q;
   assign bus.chol_step = chol_q;
   assign bus.inv_step  = inv_q;
   assign bus.sqrt_en   = sqrt_q;
   assign bus.div_en    = div_en_q;
   assign bus.div_sel   = div_sel_q;
   assign bus.mult_en   = mult_en_q;
   assign bus.mult_sel  = mult_sel_q;
endmodule

// File: tb/tb_chol_inv_sequencer.sv
// Directed bench for chol_inv_sequencer: three configurations share one clock.
// Latency: outputs sampled on the falling edge, half a cycle after they update.
// Backpressure: exercises start-while-busy, abort and mid-run reset.
module tb_chol_inv_sequencer;
   import chol_inv_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // a: N=2 default latencies, b: N=2 long divide, c: default N=6
   chol_inv_sequencer_if #(.N(2), .STEP_W(6)) ia ();
   chol_inv_sequencer_if #(.N(2), .STEP_W(6)) ib ();
   chol_inv_sequencer_if #(.N(6), .STEP_W(6)) ic ();

   chol_inv_sequencer #(.N(2), .SQRT_LAT(5), .DIV_LAT(5), .MAC_LAT(6), .STEP_W(6))
      dut_a (.clk(clk), .rst(rst), .bus(ia));
   chol_inv_sequencer #(.N(2), .SQRT_LAT(5), .DIV_LAT(8), .MAC_LAT(3), .STEP_W(6))
      dut_b (.clk(clk), .rst(rst), .bus(ib));
   chol_inv_sequencer #(.N(6), .SQRT_LAT(5), .DIV_LAT(5), .MAC_LAT(6), .STEP_W(6))
      dut_c (.clk(clk), .rst(rst), .bus(ic));

   typedef struct {
      int cyc;
      int busy;
      int done;
      int sqrt_en;
      int div_en;
      int div_sel;
      int mult_en;
      int mult_sel;
      int col;
      int chol;
      int inv;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_vec(input vec_t v);
      string p;
      p = $sformatf("a_c%0d", v.cyc);
      chk({p, "_busy"},     int'(ia.busy),      v.busy);
      chk({p, "_done"},     int'(ia.done),      v.done);
      chk({p, "_sqrt_en"},  int'(ia.sqrt_en),   v.sqrt_en);
      chk({p, "_div_en"},   int'(ia.div_en),    v.div_en);
      chk({p, "_div_sel"},  int'(ia.div_sel),   v.div_sel);
      chk({p, "_mult_en"},  int'(ia.mult_en),   v.mult_en);
      chk({p, "_mult_sel"}, int'(ia.mult_sel),  v.mult_sel);
      chk({p, "_col"},      int'(ia.col),       v.col);
      chk({p, "_chol"},     int'(ia.chol_step), v.chol);
      chk({p, "_inv"},      int'(ia.inv_step),  v.inv);
   endtask

   initial begin
      int c;
      int nb;
      int cm;
      int cmdiv;
      int dn;
      int viol;
      int guard;

      // cyc, busy, done, sqrt, div_en, div_sel, mult_en, mult_sel, col, chol, inv
      tbl[0]  = '{0,  1, 0, 1, 0, 0, 0, 0, 0, 1, 0};
      tbl[1]  = '{4,  1, 0, 1, 0, 0, 0, 0, 0, 1, 0};
      tbl[2]  = '{5,  1, 0, 0, 1, 1, 0, 0, 0, 2, 0};
      tbl[3]  = '{9,  1, 0, 0, 1, 1, 0, 0, 0, 2, 0};
      tbl[4]  = '{10, 1, 0, 0, 1, 2, 1, 1, 0, 3, 1};
      tbl[5]  = '{14, 1, 0, 0, 1, 2, 1, 1, 0, 3, 1};
      tbl[6]  = '{15, 1, 0, 0, 0, 0, 1, 1, 0, 3, 1};
      tbl[7]  = '{16, 1, 0, 0, 0, 0, 1, 2, 0, 3, 2};
      tbl[8]  = '{22, 1, 0, 1, 0, 0, 0, 0, 1, 4, 2};
      tbl[9]  = '{27, 1, 0, 0, 1, 2, 0, 0, 1, 4, 3};
      tbl[10] = '{32, 1, 0, 0, 0, 0, 1, 2, 1, 4, 4};
      tbl[11] = '{38, 0, 1, 0, 0, 0, 0, 0, 1, 4, 4};
      tbl[12] = '{39, 0, 0, 0, 0, 0, 0, 0, 1, 4, 4};

      ia.start = 1'b0; ia.abort = 1'b0;
      ib.start = 1'b0; ib.abort = 1'b0;
      ic.start = 1'b0; ic.abort = 1'b0;

      // Reset state
      #12;
      chk("rst_a_busy", int'(ia.busy), 0);
      chk("rst_a_chol", int'(ia.chol_step), 0);
      chk("rst_b_div_sel", int'(ib.div_sel), 0);
      chk("rst_c_mult_en", int'(ic.mult_en), 0);
      chk("rst_c_col", int'(ic.col), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_a_busy", int'(ia.busy), 0);

      // Cycle-by-cycle table for the N=2 run
      ia.start = 1'b1;
      @(negedge clk);
      ia.start = 1'b0;
      c = 0;
      for (int i = 0; i < 13; i++) begin
         while (c < tbl[i].cyc) begin
            @(negedge clk);
            c++;
         end
         check_vec(tbl[i]);
      end

      // Long divider: overlapped phase stretches to the divide latency
      @(negedge clk);
      ib.start = 1'b1;
      @(negedge clk);
      ib.start = 1'b0;
      nb = 0; cm = 0; cmdiv = 0; guard = 0;
      while (ib.busy && guard < 1000) begin
         nb++;
         if (ib.mult_sel == CHOL && ib.mult_en) begin
            cm++;
            if (ib.div_sel == INV && ib.div_en) cmdiv++;
         end
         @(negedge clk);
         guard++;
      end
      chk("b_busy_cycles", nb, 40);
      chk("b_cmac_cycles", cm, 8);
      chk("b_cmac_div_cycles", cmdiv, 8);
      chk("b_done", int'(ib.done), 1);
      chk("b_inv_final", int'(ib.inv_step), 4);

      // Default N=6 run with start held high throughout
      @(negedge clk);
      ic.start = 1'b1;
      @(negedge clk);
      nb = 0; viol = 0; dn = 0; guard = 0;
      while (ic.busy && guard < 2000) begin
         nb++;
         if (ic.div_en != (ic.div_sel != NONE)) viol++;
         if (ic.mult_en != (ic.mult_sel != NONE)) viol++;
         if (int'(ic.div_sel) > 2 || int'(ic.mult_sel) > 2) viol++;
         if (ic.sqrt_en && (ic.div_en || ic.mult_en)) viol++;
         if (ic.done) dn++;
         @(negedge clk);
         guard++;
      end
      ic.start = 1'b0;
      if (ic.done) dn++;
      chk("c_busy_cycles", nb, 126);
      chk("c_checker_violations", viol, 0);
      chk("c_chol_final", int'(ic.chol_step), 16);
      chk("c_inv_final", int'(ic.inv_step), 12);
      chk("c_col_final", int'(ic.col), 5);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ic.done) dn++;
         if (i == 3) chk("c_no_restart_busy", int'(ic.busy), 0);
      end
      chk("c_done_pulses", dn, 1);

      // Abort on cycle 12 of a run
      ic.start = 1'b1;
      @(negedge clk);
      ic.start = 1'b0;
      repeat (12) @(negedge clk);
      chk("abort_pre_busy", int'(ic.busy), 1);
      ic.abort = 1'b1;
      @(negedge clk);
      ic.abort = 1'b0;
      chk("abort_busy", int'(ic.busy), 0);
      chk("abort_col", int'(ic.col), 0);
      chk("abort_chol", int'(ic.chol_step), 0);
      chk("abort_inv", int'(ic.inv_step), 0);
      chk("abort_div_en", int'(ic.div_en), 0);
      chk("abort_mult_sel", int'(ic.mult_sel), 0);
      dn = 0;
      for (int i = 0; i < 150; i++) begin
         if (ic.done || ic.busy) dn++;
         @(negedge clk);
      end
      chk("abort_no_done", dn, 0);

      // Abort and start together in IDLE: abort wins
      ic.abort = 1'b1;
      ic.start = 1'b1;
      @(negedge clk);
      ic.abort = 1'b0;
      ic.start = 1'b0;
      chk("abort_start_busy", int'(ic.busy), 0);
      @(negedge clk);
      chk("abort_start_busy2", int'(ic.busy), 0);

      // Reset in the middle of the Cholesky divide, then a fresh run
      ia.start = 1'b1;
      @(negedge clk);
      ia.start = 1'b0;
      repeat (6) @(negedge clk);
      chk("mid_cdiv_sel", int'(ia.div_sel), 1);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_busy", int'(ia.busy), 0);
      chk("rst_mid_div_en", int'(ia.div_en), 0);
      chk("rst_mid_div_sel", int'(ia.div_sel), 0);
      chk("rst_mid_chol", int'(ia.chol_step), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", int'(ia.busy), 0);
      ia.start = 1'b1;
      @(negedge clk);
      ia.start = 1'b0;
      nb = 0; guard = 0;
      while (ia.busy && guard < 1000) begin
         nb++;
         @(negedge clk);
         guard++;
      end
      chk("post_rst_busy_cycles", nb, 38);
      chk("post_rst_done", int'(ia.done), 1);
      chk("post_rst_chol", int'(ia.chol_step), 4);
      chk("post_rst_inv", int'(ia.inv_step), 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/chol_inv_sequencer.md
CHOL_INV_SEQUENCER -- requirements
Module: chol_inv_sequencer

Interface
REQ-001 Parameter N, default 6: matrix dimension; legal range 2..16.
REQ-002 Parameter SQRT_LAT, default 5: square-root unit latency in cycles; must be >=1.
REQ-003 Parameter DIV_LAT, default 5: array divider latency in cycles; must be >=1.
REQ-004 Parameter MAC_LAT, default 6: array multiply-accumulate latency in cycles; must be >=1.
REQ-005 Parameter STEP_W, default 6: width of the step counters; must satisfy 2^STEP_W > 3*N.
REQ-006 Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port start, input, 1: single-cycle request to begin a factor-and-invert run.
REQ-009 Port abort, input, 1: synchronous cancel of a run in progress.
REQ-010 Port busy, output, 1: high from the first phase cycle through the last phase cycle.
REQ-011 Port done, output, 1: one-cycle pulse after a run completes normally.
REQ-012 Port col, output, $clog2(N): current column index k.
REQ-013 Port chol_step and inv_step, outputs, STEP_W each: Cholesky and inverse step numbers.
REQ-014 Port div_en, output, 1: the shared divider is active.
REQ-015 Port div_sel, output, 2 bits: divider owner (0 none, 1 cholesky, 2 inverse).
REQ-016 Port mult_en, output, 1: the shared array multiplier is active.
REQ-017 Port mult_sel, output, 2 bits: multiplier owner (0 none, 1 cholesky, 2 inverse).
REQ-018 Port sqrt_en, output, 1: the Cholesky square-root phase is active.

Function
REQ-019 The FSM shall have states IDLE, SQRT, CDIV, CMAC_IDIV, IDIV, IMAC and DONE.
REQ-020 In IDLE, start=1 shall set col=0, chol_step=1 and inv_step=0, and enter SQRT on the next edge.
REQ-021 SQRT shall last SQRT_LAT cycles, with sqrt_en=1 and div_sel and mult_sel both 0.
REQ-022 After SQRT, the FSM shall go to CDIV if col<N-1, otherwise to IDIV.
REQ-023 CDIV shall last DIV_LAT cycles, with div_en=1, div_sel=1 and chol_step incremented on entry.
REQ-024 CMAC_IDIV shall last max(MAC_LAT,DIV_LAT) cycles.
REQ-025 In CMAC_IDIV, mult_en=1 and mult_sel=1 throughout.
REQ-026 In CMAC_IDIV, div_en=1 and div_sel=2 for the first DIV_LAT cycles only, then div_en=0 and div_sel=0.
REQ-027 On entry to CMAC_IDIV, chol_step and inv_step shall each increment.
REQ-028 IDIV, used only for the last column, shall last DIV_LAT cycles with div_en=1, div_sel=2 and inv_step incremented on entry.
REQ-029 IMAC shall last MAC_LAT cycles with mult_en=1, mult_sel=2 and inv_step incremented on entry.
REQ-030 After IMAC with col<N-1, the FSM shall increment col, increment chol_step and enter SQRT.
REQ-031 After IMAC with col=N-1, the FSM shall enter DONE.
REQ-032 DONE shall last exactly one cycle with done=1, then return to IDLE.
REQ-033 In IDLE, col, chol_step and inv_step shall retain their final values.
REQ-034 A single phase counter shall load (duration-1) on phase entry and decrement each cycle; the phase exits when the counter is 0.
REQ-035 The phase counter width shall be $clog2(max(SQRT_LAT, DIV_LAT, MAC_LAT)+1).
REQ-036 busy shall be 1 exactly in states SQRT through IMAC.
REQ-037 All outputs shall be registered, with no combinational path from any input to any output.
REQ-038 start shall be ignored while busy=1 and while in DONE.
REQ-039 abort=1 while busy shall force IDLE on the next edge: every enable and sel goes to 0, done is not pulsed, and col and the step counters are cleared to 0.
REQ-040 If abort and start are both high in IDLE, abort shall win and start is ignored.
REQ-041 div_sel=1 and div_sel=2 shall never be asserted in the same cycle; the same applies to mult_sel.
REQ-042 Total busy cycles shall equal (N-1)*(SQRT_LAT+DIV_LAT+max(MAC_LAT,DIV_LAT)+MAC_LAT) + SQRT_LAT + DIV_LAT + MAC_LAT.

Reset
REQ-043 rst=1 shall asynchronously force IDLE and set every output to 0, including col, chol_step, inv_step and the phase counter.
REQ-044 Reset asserted mid-run shall discard the run; after release, the block waits for a new start.

Structure
REQ-045 Package chol_inv_pkg shall hold the phase_t enum, the owner_t encoding (NONE=0, CHOL=1, INV=2) and a MAX3 latency constant function.
REQ-046 A single sub-module, phase_timer, shall implement the loadable down-counter with a zero flag, parametrised by width.

Verification
REQ-047 With N=2, SQRT_LAT=5, DIV_LAT=5, MAC_LAT=6, a start pulse shall give busy=1 for 38 cycles, then done for 1 cycle, ending with chol_step=4 and inv_step=4.
REQ-048 With DIV_LAT=8 and MAC_LAT=3, CMAC_IDIV shall last 8 cycles, with mult_en=1 throughout and div_sel=2 for all 8 cycles.
REQ-049 An abort pulsed on cycle 12 of a default N=6 run shall give busy=0 on the next cycle, with col=0 and no done pulse.
REQ-050 start pulses applied every cycle during a run shall produce no restart, and exactly one done pulse per accepted start.
REQ-051 rst asserted mid-CDIV shall give all outputs 0 immediately; a start applied 2 cycles after release shall run to completion with the correct cycle count.
REQ-052 A checker shall assert on every cycle of a default N=6 run that owners are mutually exclusive, busy/enable consistency holds, and chol_step ends at 3N-2=16.
